cbus_mem_responder: RTL and testbench
=====================================

Name: cbus_mem_responder

Overview:
- Synthesizable cbus responder (slave): accepts cbus_req_t from an initiator (MMU, cache, arbiter) and returns cbus_resp_t beats from an internal 64-bit word memory.
- Used as the memory end of the cbus in unit/integration benches and as on-chip scratch RAM.
- Supports single and burst reads/writes (FIXED, INCR, WRAP) with byte strobes and a fixed first-beat latency.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words in storage; must be a power of two.
- LATENCY, 2, wait cycles between request acceptance and the first response beat (0 allowed).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req  input  cbus_req_t  request: valid, is_write, size, addr, strobe, data, len, burst.
- resp  output  cbus_resp_t  response: ready, last, data.

Behaviour:
- Reset (reset==0, async): state=IDLE; resp.ready=0, resp.last=0, resp.data=0; beat counter and latched request cleared. Memory contents are not cleared and are undefined until written.
- States: IDLE, WAIT, BEAT, DONE.
- IDLE:
  - On edge with req.valid=1, latch addr, is_write, len, burst.
  - Go to WAIT with counter=LATENCY, or straight to BEAT if LATENCY==0.
- WAIT:
  - Decrement the counter each cycle; go to BEAT when it reaches 1.
  - First beat is visible LATENCY+1 cycles after the cycle in which valid was first sampled.
- BEAT:
  - resp.ready=1 for exactly one cycle per beat; beats are back-to-back, one per cycle.
  - Number of beats = len+1 (MLEN1=1 … MLEN16=16).
  - resp.last=1 only on the final beat; after it, go to DONE.
- DONE:
  - Exactly one cycle with ready=0 and last=0, then IDLE.
  - Guarantees a still-high valid from the completed request is never re-accepted.
- Word index: start = addr[3+log2(MEM_WORDS)-1:3]. Addresses above the array alias modulo MEM_WORDS. addr[2:0] and size do not affect storage.
- Beat k index:
  - FIXED: start.
  - INCR: (start+k) mod MEM_WORDS, wrapping past the top to word 0.
  - WRAP: (start & ~(beats-1)) | ((start+k) & (beats-1)).
- Reads: resp.data during beat k = the full 64-bit word at index k, registered. The initiator extracts lanes.
- Writes:
  - In each beat cycle, req.data bytes with req.strobe[i]=1 are written to index k at the edge ending that cycle.
  - strobe and data are sampled live per beat; addr, len, burst and is_write use the latched copy.
  - Write beats return resp.data=0.
- Read-after-write: a read issued after a write completes returns the new data.
- Abort: if req.valid==0 in WAIT or BEAT, return to IDLE next edge with ready=0 and last=0. The current cycle's write is suppressed; earlier beats stay committed.
- Reset mid-transaction: immediate return to IDLE, outputs 0, no further writes.
- Outside BEAT, resp.ready=0 and resp.last=0; resp.data holds 0 outside beats.

Test Plan:
- LATENCY=2, write 0x1122334455667788 at addr 0x80 (MLEN1, strobe 0xFF), then read 0x80 → ready+last for exactly one cycle, 3 cycles after valid; data=0x1122334455667788; one-cycle DONE gap follows.
- INCR MLEN4 write at 0x100 with data 0xA0..0xA3 per beat, then INCR MLEN4 read → 4 consecutive ready cycles returning 0xA0,0xA1,0xA2,0xA3; last only on the 4th.
- Strobe 0x0F write of 0xFFFFFFFFFFFFFFFF over word 0 → subsequent read returns 0x00000000FFFFFFFF.
- WRAP MLEN4 read starting at word 6, after preloading words 4..7 with 4..7 → data 6,7,4,5.
- FIXED MLEN4 read at word 3 → four beats, all with word 3's value.
- INCR MLEN2 at word MEM_WORDS-1 → beats from words MEM_WORDS-1 then 0.
- Abort and reset:
  - Drop valid during beat 2 of an MLEN4 write → words 0–1 written, words 2–3 unchanged, ready=0 next cycle.
  - Assert reset mid-WAIT → outputs 0 immediately and the next request is accepted normally.
- LATENCY=0 instance → first ready appears in the cycle after valid is sampled.

Source files
------------

// File: rtl/cbus_mem_responder.sv
// cbus memory responder: a word-addressed 64-bit scratch memory behind a cbus
// slave port. It accepts one request at a time, waits a fixed number of cycles,
// then streams single or burst beats (FIXED / INCR / WRAP) with byte strobes on
// writes. The same file carries the cbus type package so the block stands alone.

package cbus_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_t;

    // Encoded burst length: value + 1 beats.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN3  = 4'd2,
        MLEN4  = 4'd3,
        MLEN5  = 4'd4,
        MLEN6  = 4'd5,
        MLEN7  = 4'd6,
        MLEN8  = 4'd7,
        MLEN9  = 4'd8,
        MLEN10 = 4'd9,
        MLEN11 = 4'd10,
        MLEN12 = 4'd11,
        MLEN13 = 4'd12,
        MLEN14 = 4'd13,
        MLEN15 = 4'd14,
        MLEN16 = 4'd15
    } mlen_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        strobe;
        logic [63:0]       data;
        mlen_t             len;
        burst_t            burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module cbus_mem_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  req,
    output cbus_resp_t resp
);

    localparam int AW = $clog2(MEM_WORDS);
    // Latency counter wide enough to hold LATENCY (at least one bit).
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BEAT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Word index of beat k for a burst starting at word 'start'. WRAP keeps the
    // block-aligned upper bits and lets the low bits (selected by len) roll over.
    function automatic logic [AW-1:0] beat_index(
        input logic [AW-1:0] start,
        input logic [3:0]    k,
        input logic [3:0]    len,
        input burst_t        burst
    );
        logic [AW-1:0] k_w;
        logic [AW-1:0] mask_w;
        logic [AW-1:0] idx;
        k_w    = AW'(k);
        mask_w = AW'(len);
        case (burst)
            BURST_FIXED: idx = start;
            BURST_INCR:  idx = start + k_w;
            BURST_WRAP:  idx = (start & ~mask_w) | ((start + k_w) & mask_w);
            default:     idx = start;
        endcase
        return idx;
    endfunction

    // Storage; intentionally not reset.
    logic [63:0]   mem_q [MEM_WORDS];

    state_t        state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [3:0]    beat_q,       beat_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic [AW-1:0] start_q,      start_d;
    logic [3:0]    len_q,        len_d;
    burst_t        burst_q,      burst_d;
    logic          is_write_q,   is_write_d;
    logic          resp_ready_q, resp_ready_d;
    logic          resp_last_q,  resp_last_d;
    logic [63:0]   resp_data_q;

    logic          rd_en_s;
    logic          wr_en_s;
    logic [AW-1:0] req_start_s;
    logic          unused_req_bits_s;

    assign req_start_s = req.addr[AW+2:3];

    // Size, byte offset and aliased upper address bits do not affect storage.
    assign unused_req_bits_s = ^{req.size, req.addr[2:0], req.addr[ADDR_W-1:AW+3]};

    // A write beat commits only while the initiator still holds valid.
    assign wr_en_s = (state_q == S_BEAT) && req.valid && is_write_q;

    // Next-state, beat sequencing and next response flags.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        idx_d        = idx_q;
        start_d      = start_q;
        len_d        = len_q;
        burst_d      = burst_q;
        is_write_d   = is_write_q;
        resp_ready_d = 1'b0;
        resp_last_d  = 1'b0;
        rd_en_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req.valid) begin
                    start_d    = req_start_s;
                    len_d      = req.len;
                    burst_d    = req.burst;
                    is_write_d = req.is_write;
                    beat_d     = 4'd0;
                    idx_d      = req_start_s;
                    if (LATENCY == 0) begin
                        state_d      = S_BEAT;
                        cnt_d        = '0;
                        resp_ready_d = 1'b1;
                        resp_last_d  = (req.len == MLEN1);
                        rd_en_s      = !req.is_write;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (!req.valid) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= CW'(1)) begin
                    state_d      = S_BEAT;
                    beat_d       = 4'd0;
                    idx_d        = start_q;
                    resp_ready_d = 1'b1;
                    resp_last_d  = (len_q == 4'd0);
                    rd_en_s      = !is_write_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_BEAT: begin
                if (!req.valid) begin
                    state_d = S_IDLE;
                end else if (beat_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    beat_d       = beat_q + 4'd1;
                    idx_d        = beat_index(start_q, beat_q + 4'd1, len_q, burst_q);
                    resp_ready_d = 1'b1;
                    resp_last_d  = ((beat_q + 4'd1) == len_q);
                    rd_en_s      = !is_write_q;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, latched request fields and response flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            beat_q       <= 4'd0;
            idx_q        <= '0;
            start_q      <= '0;
            len_q        <= 4'd0;
            burst_q      <= BURST_FIXED;
            is_write_q   <= 1'b0;
            resp_ready_q <= 1'b0;
            resp_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            idx_q        <= idx_d;
            start_q      <= start_d;
            len_q        <= len_d;
            burst_q      <= burst_d;
            is_write_q   <= is_write_d;
            resp_ready_q <= resp_ready_d;
            resp_last_q  <= resp_last_d;
        end
    end

    // Registered read data for the upcoming read beat; zero everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data_q <= 64'd0;
        end else if (rd_en_s) begin
            resp_data_q <= mem_q[idx_d];
        end else begin
            resp_data_q <= 64'd0;
        end
    end

    // Byte-strobed memory write at the edge ending each live write beat.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 8; i++) begin
                if (req.strobe[i]) begin
                    mem_q[idx_q][8*i +: 8] <= req.data[8*i +: 8];
                end
            end
        end
    end

    assign resp = '{ready: resp_ready_q, last: resp_last_q, data: resp_data_q};

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Bench for cbus_mem_responder: a table of transactions applied to a
// LATENCY=2 instance, with expected beats queued per transaction and popped by
// a response monitor, plus hand-written abort/reset sequences and a LATENCY=0
// instance.
module tb_cbus_mem_responder;
    import cbus_pkg::*;

    localparam int LAT = 2;
    localparam int MW0 = 64;
    localparam int MW1 = 16;

    logic       clk;
    logic       rst_n;
    cbus_req_t  req0;
    cbus_resp_t resp0;
    cbus_req_t  req1;
    cbus_resp_t resp1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        mlen_t       len;
        burst_t      burst;
        logic [7:0]  strb;
        logic [63:0] wbase;
        int          abort_k;
        logic [63:0] exp [4];
    } vec_t;

    vec_t vecs[$];

    cbus_mem_responder #(.MEM_WORDS(MW0), .LATENCY(LAT)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .req   (req0),
        .resp  (resp0)
    );

    cbus_mem_responder #(.MEM_WORDS(MW1), .LATENCY(0)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .req   (req1),
        .resp  (resp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic wr, input logic [31:0] addr, input mlen_t len,
                                 input burst_t burst, input logic [7:0] strb,
                                 input logic [63:0] wbase, input int abort_k,
                                 input logic [63:0] e0, input logic [63:0] e1,
                                 input logic [63:0] e2, input logic [63:0] e3);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.strb = strb;
        v.wbase = wbase; v.abort_k = abort_k;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Monitor: every ready beat on dut0 must match the head of the queue.
    always @(negedge clk) begin : mon
        beat_t b;
        if (rst_n && resp0.ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", resp0.data, b.data);
                check("beat_last", {63'd0, resp0.last}, {63'd0, b.last});
            end
        end
    end

    // Drive one transaction on dut0 starting at a negedge; checks per-cycle
    // ready/last timing and returns at a negedge one idle cycle after DONE.
    task automatic run_vec(input vec_t v);
        int    nb;
        int    k;
        logic  in_beat;
        logic  exp_last;
        beat_t b;
        nb = (v.abort_k >= 0) ? v.abort_k + 1 : int'(v.len) + 1;
        for (int i = 0; i < nb; i++) begin
            b.data = v.wr ? 64'd0 : v.exp[i];
            b.last = (i == int'(v.len));
            exp_q.push_back(b);
        end
        req0.valid    = 1'b1;
        req0.is_write = v.wr;
        req0.size     = 3'd3;
        req0.addr     = v.addr;
        req0.len      = v.len;
        req0.burst    = v.burst;
        req0.strobe   = v.strb;
        req0.data     = v.wbase;
        for (int c = 1; c <= LAT + nb + 1; c++) begin
            @(negedge clk);
            k        = c - (LAT + 1);
            in_beat  = (k >= 0) && (k < nb);
            exp_last = in_beat && (k == int'(v.len));
            check("beat_timing", {62'd0, resp0.ready, resp0.last}, {62'd0, in_beat, exp_last});
            if (in_beat && (k == v.abort_k)) begin
                req0.valid = 1'b0;
            end else if (in_beat) begin
                req0.data = v.wbase + 64'(k);
            end else if (k >= nb) begin
                req0.valid = 1'b0;
            end
        end
        check("beats_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        beat_t b;

        // Transaction table: {write?, addr, len, burst, strobe, write base, abort beat, expected read beats}
        vecs.push_back(mkv(1'b1, 32'h080, MLEN1, BURST_INCR,  8'hFF, 64'h1122334455667788, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h080, MLEN1, BURST_INCR,  8'hFF, 64'd0, -1, 64'h1122334455667788, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b1, 32'h100, MLEN4, BURST_INCR,  8'hFF, 64'hA0, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h100, MLEN4, BURST_INCR,  8'hFF, 64'd0, -1, 64'hA0, 64'hA1, 64'hA2, 64'hA3));
        vecs.push_back(mkv(1'b1, 32'h000, MLEN1, BURST_INCR,  8'hFF, 64'd0, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b1, 32'h000, MLEN1, BURST_INCR,  8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h000, MLEN1, BURST_INCR,  8'hFF, 64'd0, -1, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b1, 32'h020, MLEN4, BURST_INCR,  8'hFF, 64'd4, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h030, MLEN4, BURST_WRAP,  8'hFF, 64'd0, -1, 64'd6, 64'd7, 64'd4, 64'd5));
        vecs.push_back(mkv(1'b1, 32'h018, MLEN1, BURST_INCR,  8'hFF, 64'h3333, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h018, MLEN4, BURST_FIXED, 8'hFF, 64'd0, -1, 64'h3333, 64'h3333, 64'h3333, 64'h3333));
        vecs.push_back(mkv(1'b1, 32'h1F8, MLEN2, BURST_INCR,  8'hFF, 64'h6300, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h1F8, MLEN2, BURST_INCR,  8'hFF, 64'd0, -1, 64'h6300, 64'h6301, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h000, MLEN1, BURST_INCR,  8'hFF, 64'd0, -1, 64'h6301, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h3FF, MLEN1, BURST_INCR,  8'hFF, 64'd0, -1, 64'h6300, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b1, 32'h040, MLEN4, BURST_INCR,  8'hFF, 64'hB0, -1, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b1, 32'h040, MLEN4, BURST_INCR,  8'hFF, 64'hC0,  2, 64'd0, 64'd0, 64'd0, 64'd0));
        vecs.push_back(mkv(1'b0, 32'h040, MLEN4, BURST_INCR,  8'hFF, 64'd0, -1, 64'hC0, 64'hC1, 64'hB2, 64'hB3));

        req0  = '0;
        req1  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy_last0", {62'd0, resp0.ready, resp0.last}, 64'd0);
        check("rst_data0",     resp0.data, 64'd0);
        check("rst_rdy_last1", {62'd0, resp1.ready, resp1.last}, 64'd0);
        check("rst_data1",     resp1.data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Reset during the first beat of a read burst: outputs drop at once.
        b.data = 64'hA0; b.last = 1'b0;
        exp_q.push_back(b);
        req0.valid = 1'b1; req0.is_write = 1'b0; req0.addr = 32'h100;
        req0.len = MLEN4; req0.burst = BURST_INCR;
        repeat (LAT + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_beat_rdy_last", {62'd0, resp0.ready, resp0.last}, 64'd0);
        check("rst_beat_data",     resp0.data, 64'd0);
        req0.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_beat_idle",    {62'd0, resp0.ready, resp0.last}, 64'd0);
        check("rst_beat_drained", 64'(exp_q.size()), 64'd0);
        run_vec(vecs[1]);

        // Reset while waiting: nothing comes out, next request works normally.
        req0.valid = 1'b1; req0.is_write = 1'b0; req0.addr = 32'h080;
        req0.len = MLEN1; req0.burst = BURST_INCR;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_rdy_last", {62'd0, resp0.ready, resp0.last}, 64'd0);
        req0.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check("rst_wait_quiet", {62'd0, resp0.ready, resp0.last}, 64'd0);
        end
        run_vec(vecs[3]);

        // LATENCY=0 instance: first beat in the cycle right after acceptance.
        req1.valid = 1'b1; req1.is_write = 1'b1; req1.size = 3'd3; req1.addr = 32'h010;
        req1.len = MLEN1; req1.burst = BURST_INCR; req1.strobe = 8'hFF;
        req1.data = 64'h5A5A_0000_1234_0001;
        @(negedge clk);
        check("l0_wr_rdy_last", {62'd0, resp1.ready, resp1.last}, {62'd0, 1'b1, 1'b1});
        check("l0_wr_data",     resp1.data, 64'd0);
        @(negedge clk);
        check("l0_wr_done", {62'd0, resp1.ready, resp1.last}, 64'd0);
        req1.valid = 1'b0;
        @(negedge clk);
        req1.valid = 1'b1; req1.is_write = 1'b0; req1.data = 64'd0;
        @(negedge clk);
        check("l0_rd_rdy_last", {62'd0, resp1.ready, resp1.last}, {62'd0, 1'b1, 1'b1});
        check("l0_rd_data",     resp1.data, 64'h5A5A_0000_1234_0001);
        @(negedge clk);
        check("l0_rd_done", {62'd0, resp1.ready, resp1.last}, 64'd0);
        req1.valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
